uart_transmitter: RTL and testbench

UART transmit side, companion to the receiver block: serialises one 8-bit byte per request onto the Tx line, LSB first.
- Frame: start bit, 8 data bits, optional even/odd parity bit, 1 or 2 stop bits.
- Configuration encodings are shared with the receiver so both ends of a link are configured identically.
- Sits between the host-side byte source and the serial pin.

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/uart_tx_baud_gen.sv | 35 +++
 rtl/uart_transmitter.sv | 150 +++++++++++++++
 tb/tb_uart_transmitter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART link constants: baud/parity/stop encodings, bit divisor helper,
// parity helper and the transmitter FSM state encoding.
package uart_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic [1:0] PARITY_EVEN = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_NONE = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  // Clocks per bit for a baud code, truncated.
  function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                input logic [1:0] baud);
    int unsigned rate;
    case (baud)
      BAUD_9600:   rate = 32'd9600;
      BAUD_19200:  rate = 32'd19200;
      BAUD_57600:  rate = 32'd57600;
      BAUD_115200: rate = 32'd115200;
      default:     rate = 32'd115200;
    endcase
    return clk_freq / rate;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Loadable down-counter that emits a one-cycle bit tick every div clocks
// while enabled; restart reloads it so a new frame starts a full bit period.
module uart_tx_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] count;

  // Count down to zero, reloading with div-1 at terminal count or restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart) begin
      count <= div - 32'd1;
    end else if (enable) begin
      if (count == '0) begin
        count <= div - 32'd1;
      end else begin
        count <= count - 32'd1;
      end
    end else begin
      count <= count;
    end
  end

  assign bit_tick = enable && !restart && (count == '0);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per accepted request, LSB first, with
// optional parity and one or two stop bits; Tx, TxBusy and TxDone are flops.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] BaudRate,
  input  logic [1:0] ParityMode,
  input  logic       StopBits,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  output logic       Tx,
  output logic       TxBusy,
  output logic       TxDone
);

  tx_state_e        state, state_next;
  logic [2:0]       bit_index, bit_index_next;
  logic [7:0]       shifter, shifter_next;
  logic             tx_next, done_next;
  logic             parity_on, parity_val, two_stop;
  logic [DIV_W-1:0] div_latched, div_load;
  logic             accept, bit_tick;

  assign accept   = TxStart && !TxBusy;
  assign div_load = accept ? baud_div(CLK_FREQ, BaudRate) : div_latched;

  uart_tx_baud_gen u_baud (
    .clk      (CLK),
    .rst      (RST),
    .enable   (TxBusy),
    .restart  (accept),
    .div      (div_load),
    .bit_tick (bit_tick)
  );

  // Frame configuration is captured only at acceptance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      parity_on   <= 1'b0;
      parity_val  <= 1'b0;
      two_stop    <= 1'b0;
      div_latched <= '0;
    end else if (accept) begin
      parity_on   <= !ParityMode[1];
      parity_val  <= parity_bit(TxData, ParityMode);
      two_stop    <= (StopBits == STOP_TWO);
      div_latched <= div_load;
    end else begin
      parity_on   <= parity_on;
      parity_val  <= parity_val;
      two_stop    <= two_stop;
      div_latched <= div_latched;
    end
  end

  // State, shifter and registered line outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      bit_index <= 3'd0;
      shifter   <= 8'd0;
      Tx        <= 1'b1;
      TxBusy    <= 1'b0;
      TxDone    <= 1'b0;
    end else begin
      state     <= state_next;
      bit_index <= bit_index_next;
      shifter   <= shifter_next;
      Tx        <= tx_next;
      TxBusy    <= (state_next != ST_IDLE);
      TxDone    <= done_next;
    end
  end

  // Next state and next line value; tx_next is the level for the coming cycle.
  always_comb begin
    state_next     = state;
    bit_index_next = bit_index;
    shifter_next   = shifter;
    tx_next        = 1'b1;
    done_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next   = ST_START;
          shifter_next = TxData;
          tx_next      = 1'b0;
        end else begin
          tx_next = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_next     = ST_DATA;
          bit_index_next = 3'd0;
          tx_next        = shifter[0];
        end else begin
          tx_next = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shifter_next = {1'b0, shifter[7:1]};
          if (bit_index == 3'd7) begin
            state_next = parity_on ? ST_PARITY : ST_STOP1;
            tx_next    = parity_on ? parity_val : 1'b1;
          end else begin
            bit_index_next = bit_index + 3'd1;
            tx_next        = shifter[1];
          end
        end else begin
          tx_next = shifter[0];
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_next = ST_STOP1;
          tx_next    = 1'b1;
        end else begin
          tx_next = parity_val;
        end
      end
      ST_STOP1: begin
        if (bit_tick) begin
          state_next = two_stop ? ST_STOP2 : ST_IDLE;
          done_next  = !two_stop;
        end else begin
          tx_next = 1'b1;
        end
      end
      ST_STOP2: begin
        if (bit_tick) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          tx_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed and randomized frames compared per clock
// against a bit-list model of the frame built from the byte and configuration.
module tb_uart_transmitter;

  localparam int unsigned CLK_FREQ = 1_152_000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] BaudRate = 2'b00;
  logic [1:0] ParityMode = 2'b00;
  logic       StopBits = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxStart = 1'b0;
  logic       Tx, TxBusy, TxDone;

  int n_total = 0;
  int n_pass  = 0;
  int unsigned rates [4] = '{32'd9600, 32'd19200, 32'd57600, 32'd115200};

  uart_transmitter #(.CLK_FREQ(CLK_FREQ)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BaudRate   (BaudRate),
    .ParityMode (ParityMode),
    .StopBits   (StopBits),
    .TxData     (TxData),
    .TxStart    (TxStart),
    .Tx         (Tx),
    .TxBusy     (TxBusy),
    .TxDone     (TxDone)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] line_state();
    return {29'd0, Tx, TxBusy, TxDone};
  endfunction

  task automatic launch(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pm,
                        input logic sb);
    @(negedge CLK);
    TxData = d; BaudRate = br; ParityMode = pm; StopBits = sb; TxStart = 1'b1;
    @(negedge CLK);
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    check({tag, " idle_after"}, line_state(), 32'd4);
  endtask

  // Starts at the negedge right after acceptance (k=0) and ends at the done cycle.
  // mode 0: plain; 1: re-request with other inputs mid-frame; 2: hold TxStart for a follow-on frame.
  task automatic capture(input logic [7:0] d, input logic [1:0] br, input logic [1:0] pm,
                         input logic sb, input int mode, input string tag);
    bit   bits[$];
    int   div, len, tx_bad, busy_bad, done_cnt, done_at;
    logic exp_tx, exp_busy;
    div = int'(CLK_FREQ / rates[br]);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm == 2'b00) bits.push_back($countones(d) % 2 == 1);
    else if (pm == 2'b01) bits.push_back($countones(d) % 2 == 0);
    bits.push_back(1'b1);
    if (sb) bits.push_back(1'b1);
    len = bits.size() * div;
    tx_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
    for (int k = 0; k <= len; k++) begin
      exp_tx   = (k < len) ? bits[k / div] : 1'b1;
      exp_busy = (k < len);
      if (Tx !== exp_tx) tx_bad++;
      if (TxBusy !== exp_busy) busy_bad++;
      if (TxDone === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 0 && mode != 2) TxStart = 1'b0;
      if (mode == 1 && k == len / 2) begin
        TxStart = 1'b1; TxData = 8'hFF; BaudRate = ~br; ParityMode = ~pm; StopBits = ~sb;
      end
      if (mode == 1 && k == len / 2 + 2) TxStart = 1'b0;
      if (mode == 2 && k == 1) TxData = ~d;
      if (k < len) @(negedge CLK);
    end
    check({tag, " tx_wave_bad_clocks"}, tx_bad, 32'd0);
    check({tag, " busy_wave_bad_clocks"}, busy_bad, 32'd0);
    check({tag, " done_cycle"}, done_at, len);
    check({tag, " done_pulses"}, done_cnt, 32'd1);
  endtask

  task automatic reset_mid(input int cyc, input string tag);
    launch(8'($urandom), 2'b11, 2'($urandom_range(0, 2)), 1'($urandom));
    TxStart = 1'b0;
    repeat (cyc) @(negedge CLK);
    #2 RST = 1'b1;
    #1 check({tag, " async_reset"}, line_state(), 32'd4);
    @(negedge CLK);
    check({tag, " reset_held"}, line_state(), 32'd4);
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rbr, rpm;
    logic       rsb;
    int         rmode;

    repeat (2) @(negedge CLK);
    check("reset_state", line_state(), 32'd4);
    RST = 1'b0;
    @(negedge CLK);
    check("after_release", line_state(), 32'd4);

    launch(8'hA5, 2'b11, 2'b10, 1'b0); capture(8'hA5, 2'b11, 2'b10, 1'b0, 0, "a5_nopar"); idle_check("a5");
    launch(8'h07, 2'b11, 2'b00, 1'b0); capture(8'h07, 2'b11, 2'b00, 1'b0, 0, "07_even"); idle_check("07e");
    launch(8'h07, 2'b11, 2'b01, 1'b0); capture(8'h07, 2'b11, 2'b01, 1'b0, 0, "07_odd"); idle_check("07o");
    launch(8'h07, 2'b11, 2'b01, 1'b1); capture(8'h07, 2'b11, 2'b01, 1'b1, 0, "07_odd_2stop"); idle_check("07s");

    launch(8'h5A, 2'b11, 2'b00, 1'b0); capture(8'h5A, 2'b11, 2'b00, 1'b0, 1, "ignore_ff"); idle_check("ign");

    launch(8'h3C, 2'b11, 2'b10, 1'b0); capture(8'h3C, 2'b11, 2'b10, 1'b0, 2, "b2b_first");
    @(negedge CLK);
    capture(8'hC3, 2'b11, 2'b10, 1'b0, 0, "b2b_second"); idle_check("b2b");

    launch(8'h96, 2'b00, 2'b01, 1'b1); capture(8'h96, 2'b00, 2'b01, 1'b1, 1, "slow_baud"); idle_check("slow");
    launch(8'h69, 2'b11, 2'b01, 1'b1); capture(8'h69, 2'b11, 2'b01, 1'b1, 0, "fast_after"); idle_check("fast");

    for (int i = 0; i < 3; i++) begin
      reset_mid($urandom_range(1, 90), "reset_mid");
      launch(8'hE1, 2'b11, 2'b00, 1'b1); capture(8'hE1, 2'b11, 2'b00, 1'b1, 0, "post_reset");
      idle_check("post_reset");
    end

    for (int i = 0; i < 24; i++) begin
      rd    = 8'($urandom);
      rbr   = 2'($urandom_range(0, 3));
      rpm   = 2'($urandom_range(0, 3));
      rsb   = 1'($urandom);
      rmode = $urandom_range(0, 1);
      launch(rd, rbr, rpm, rsb);
      capture(rd, rbr, rpm, rsb, rmode, "random");
      idle_check("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
